// File: rtl/usb_buf_pkg.sv
// Shared defaults, endpoint-operation encoding and width helper for the
// multi-endpoint USB data buffer.
package usb_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_NUM_EP = 4;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_CLR
    } ep_op_e;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/usb_ep_fifo_ctrl.sv
// Pointer, count and full/empty bookkeeping for one endpoint FIFO.
// Takes arbitrated push/pop requests plus clear and reports which ops took effect.
module usb_ep_fifo_ctrl
    import usb_buf_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int OCW   = occ_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_req,
    input  logic           pop_req,
    input  logic           clr,
    output logic           push_ok,
    output logic           pop_ok,
    output logic [PW-1:0]  wr_ptr,
    output logic [PW-1:0]  rd_ptr,
    output logic [OCW-1:0] count,
    output logic           empty,
    output logic           full
);

    ep_op_e op;

    assign empty = (count == '0);
    assign full  = (count == OCW'(DEPTH));

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign pop_ok  = pop_req && !clr && !empty;
    assign push_ok = push_req && !clr && (!full || pop_ok);

    always_comb begin
        op = OP_NONE;
        if (clr)
            op = OP_CLR;
        else if (push_ok && !pop_ok)
            op = OP_PUSH;
        else if (pop_ok && !push_ok)
            op = OP_POP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (op == OP_CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            case (op)
                OP_PUSH: count <= count + OCW'(1);
                OP_POP:  count <= count - OCW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/usb_ep_buffer.sv
// NUM_EP independent circular FIFOs shared by a host side and a packet side.
// Optional build macro USB_EP_BUF_WATERMARK_EN adds host_almost_full and ovf_sticky.
module usb_ep_buffer
    import usb_buf_pkg::*;
#(
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  DEPTH     = DEF_DEPTH,
    parameter int  NUM_EP    = DEF_NUM_EP,
`ifdef USB_EP_BUF_WATERMARK_EN
    parameter int  WATERMARK = 48,
`endif
    localparam int EPW       = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
    localparam int OCW       = occ_width(DEPTH),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [EPW-1:0]    host_ep,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              get_rx_data,
    output logic [DATA_W-1:0] rx_data,
    input  logic              clear,
    input  logic [EPW-1:0]    pkt_ep,
    input  logic              store_rx_packet_data,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              get_tx_packet_data,
    output logic [DATA_W-1:0] tx_packet_data,
    input  logic              flush,
    output logic [OCW-1:0]    buffer_occupancy,
    output logic [OCW-1:0]    pkt_occupancy,
    output logic              host_empty,
    output logic              host_full,
    output logic              pkt_empty,
    output logic              pkt_full,
`ifdef USB_EP_BUF_WATERMARK_EN
    output logic              host_almost_full,
    output logic [NUM_EP-1:0] ovf_sticky,
`endif
    output logic              overflow_err,
    output logic              underflow_err
);

    logic [NUM_EP-1:0] h_push, p_push, h_pop, p_pop, clr;
    logic [NUM_EP-1:0] push_ok, pop_ok, ovf, unf, ep_empty, ep_full;
    logic [PW-1:0]     wr_ptr [NUM_EP];
    logic [PW-1:0]     rd_ptr [NUM_EP];
    logic [OCW-1:0]    count  [NUM_EP];
    logic [DATA_W-1:0] mem    [NUM_EP][DEPTH];

    // Out-of-range selects match no endpoint, so their ops fall away here.
    for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
        assign h_push[g] = store_tx_data        && (host_ep == EPW'(g));
        assign p_push[g] = store_rx_packet_data && (pkt_ep  == EPW'(g));
        assign h_pop[g]  = get_rx_data          && (host_ep == EPW'(g));
        assign p_pop[g]  = get_tx_packet_data   && (pkt_ep  == EPW'(g));
        assign clr[g]    = (clear && (host_ep == EPW'(g))) || (flush && (pkt_ep == EPW'(g)));

        // Losing side of a same-endpoint collision counts as an error too.
        assign ovf[g] = !clr[g] && (((h_push[g] || p_push[g]) && !push_ok[g]) || (h_push[g] && p_push[g]));
        assign unf[g] = !clr[g] && (((h_pop[g] || p_pop[g]) && !pop_ok[g]) || (h_pop[g] && p_pop[g]));

        usb_ep_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
            .clk      (clk),
            .rst      (rst),
            .push_req (h_push[g] || p_push[g]),
            .pop_req  (h_pop[g] || p_pop[g]),
            .clr      (clr[g]),
            .push_ok  (push_ok[g]),
            .pop_ok   (pop_ok[g]),
            .wr_ptr   (wr_ptr[g]),
            .rd_ptr   (rd_ptr[g]),
            .count    (count[g]),
            .empty    (ep_empty[g]),
            .full     (ep_full[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_EP; e++) begin
            if (push_ok[e])
                mem[e][wr_ptr[e]] <= h_push[e] ? tx_data : rx_packet_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data        <= '0;
            tx_packet_data <= '0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            overflow_err  <= |ovf;
            underflow_err <= |unf;
            for (int e = 0; e < NUM_EP; e++) begin
                if (pop_ok[e] && p_pop[e])
                    tx_packet_data <= mem[e][rd_ptr[e]];
                else if (pop_ok[e] && h_pop[e])
                    rx_data <= mem[e][rd_ptr[e]];
            end
        end
    end

    always_comb begin
        buffer_occupancy = '0;
        host_empty       = 1'b1;
        host_full        = 1'b0;
        pkt_occupancy    = '0;
        pkt_empty        = 1'b1;
        pkt_full         = 1'b0;
        for (int e = 0; e < NUM_EP; e++) begin
            if (host_ep == EPW'(e)) begin
                buffer_occupancy = count[e];
                host_empty       = ep_empty[e];
                host_full        = ep_full[e];
            end
            if (pkt_ep == EPW'(e)) begin
                pkt_occupancy = count[e];
                pkt_empty     = ep_empty[e];
                pkt_full      = ep_full[e];
            end
        end
    end

`ifdef USB_EP_BUF_WATERMARK_EN
    assign host_almost_full = (buffer_occupancy >= OCW'(WATERMARK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_sticky <= '0;
        else
            ovf_sticky <= (ovf_sticky & ~clr) | ovf;
    end
`endif

endmodule

// File: tb/tb_usb_ep_buffer.sv
// Directed self-checking bench for usb_ep_buffer (default parameters).
// Watermark checks are compiled in when USB_EP_BUF_WATERMARK_EN is defined.
module tb_usb_ep_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] host_ep = '0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = '0;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       clear = 1'b0;
    logic [1:0] pkt_ep = '0;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = '0;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] tx_packet_data;
    logic       flush = 1'b0;
    logic [6:0] buffer_occupancy, pkt_occupancy;
    logic       host_empty, host_full, pkt_empty, pkt_full;
    logic       overflow_err, underflow_err;
`ifdef USB_EP_BUF_WATERMARK_EN
    logic       host_almost_full;
    logic [3:0] ovf_sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_ep_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .host_ep              (host_ep),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .clear                (clear),
        .pkt_ep               (pkt_ep),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .flush                (flush),
        .buffer_occupancy     (buffer_occupancy),
        .pkt_occupancy        (pkt_occupancy),
        .host_empty           (host_empty),
        .host_full            (host_full),
        .pkt_empty            (pkt_empty),
        .pkt_full             (pkt_full),
`ifdef USB_EP_BUF_WATERMARK_EN
        .host_almost_full     (host_almost_full),
        .ovf_sticky           (ovf_sticky),
`endif
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        store_tx_data = 0; get_rx_data = 0; clear = 0;
        store_rx_packet_data = 0; get_tx_packet_data = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (tx_packet_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_packet_data); end
        checks++; if ({buffer_occupancy, pkt_occupancy} !== 14'd0) begin errors++; $display("FAIL reset_occ got %0d/%0d want 0/0", buffer_occupancy, pkt_occupancy); end
        checks++; if ({host_empty, host_full, pkt_empty, pkt_full, overflow_err, underflow_err} !== 6'b101000) begin
            errors++; $display("FAIL reset_status got %b want 101000", {host_empty, host_full, pkt_empty, pkt_full, overflow_err, underflow_err}); end
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        host_ep = 1; pkt_ep = 1;
        store_tx_data = 1; tx_data = 8'hA5; tick();
        tx_data = 8'h3C; tick();
        idle();
        checks++; if (pkt_occupancy !== 7'd2) begin errors++; $display("FAIL basic_occ2 got %0d want 2", pkt_occupancy); end
        get_tx_packet_data = 1; tick();
        checks++; if (tx_packet_data !== 8'hA5) begin errors++; $display("FAIL basic_pop1 got %h want a5", tx_packet_data); end
        checks++; if (pkt_occupancy !== 7'd1) begin errors++; $display("FAIL basic_occ1 got %0d want 1", pkt_occupancy); end
        tick();
        checks++; if (tx_packet_data !== 8'h3C) begin errors++; $display("FAIL basic_pop2 got %h want 3c", tx_packet_data); end
        checks++; if (pkt_occupancy !== 7'd0 || pkt_empty !== 1'b1) begin errors++; $display("FAIL basic_occ0 got %0d/%b want 0/1", pkt_occupancy, pkt_empty); end
        idle(); tick();
        checks++; if (tx_packet_data !== 8'h3C) begin errors++; $display("FAIL basic_hold got %h want 3c", tx_packet_data); end
    endtask

    task automatic test_full();
        host_ep = 0; pkt_ep = 0;
        store_rx_packet_data = 1;
        for (int i = 0; i < 64; i++) begin
            rx_packet_data = 8'h40 + 8'(i);
            tick();
        end
        checks++; if (buffer_occupancy !== 7'd64 || host_full !== 1'b1) begin errors++; $display("FAIL full_occ got %0d/%b want 64/1", buffer_occupancy, host_full); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b want 0", overflow_err); end
        rx_packet_data = 8'hFF; tick();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", overflow_err); end
        checks++; if (buffer_occupancy !== 7'd64) begin errors++; $display("FAIL full_ovf_occ got %0d want 64", buffer_occupancy); end
        idle(); tick();
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL full_ovf_pulse got %b want 0", overflow_err); end
        get_rx_data = 1; tick(); idle();
        checks++; if (rx_data !== 8'h40 || buffer_occupancy !== 7'd63) begin errors++; $display("FAIL full_pop got %h/%0d want 40/63", rx_data, buffer_occupancy); end
        store_rx_packet_data = 1; rx_packet_data = 8'h80; tick();
        rx_packet_data = 8'h81; get_rx_data = 1; tick(); idle();
        checks++; if (buffer_occupancy !== 7'd64 || overflow_err !== 1'b0) begin errors++; $display("FAIL full_pushpop got %0d/%b want 64/0", buffer_occupancy, overflow_err); end
        checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL full_pushpop_data got %h want 41", rx_data); end
        clear = 1; tick(); idle();
        checks++; if (buffer_occupancy !== 7'd0 || host_empty !== 1'b1) begin errors++; $display("FAIL full_clear got %0d/%b want 0/1", buffer_occupancy, host_empty); end
    endtask

    task automatic test_underflow();
        host_ep = 2; get_rx_data = 1; tick(); idle();
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL unf_pulse got %b want 1", underflow_err); end
        checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL unf_hold got %h want 41", rx_data); end
        tick();
        checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", underflow_err); end
    endtask

    task automatic test_flush_priority();
        host_ep = 3; pkt_ep = 3;
        store_tx_data = 1;
        for (int i = 0; i < 10; i++) begin
            tx_data = 8'h30 + 8'(i);
            tick();
        end
        idle();
        checks++; if (pkt_occupancy !== 7'd10) begin errors++; $display("FAIL flush_fill got %0d want 10", pkt_occupancy); end
        store_tx_data = 1; tx_data = 8'h3A; get_tx_packet_data = 1; tick();
        checks++; if (pkt_occupancy !== 7'd10 || tx_packet_data !== 8'h30) begin errors++; $display("FAIL flush_pushpop got %0d/%h want 10/30", pkt_occupancy, tx_packet_data); end
        flush = 1; tick(); idle();
        checks++; if (pkt_occupancy !== 7'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", pkt_occupancy); end
        checks++; if ({overflow_err, underflow_err} !== 2'b00 || tx_packet_data !== 8'h30) begin
            errors++; $display("FAIL flush_noerr got %b/%h want 00/30", {overflow_err, underflow_err}, tx_packet_data); end
    endtask

    task automatic test_collision();
        host_ep = 1; pkt_ep = 1;
        store_tx_data = 1; tx_data = 8'h11;
        store_rx_packet_data = 1; rx_packet_data = 8'h22;
        tick(); idle();
        checks++; if (overflow_err !== 1'b1 || buffer_occupancy !== 7'd1) begin errors++; $display("FAIL coll_push got %b/%0d want 1/1", overflow_err, buffer_occupancy); end
        get_rx_data = 1; get_tx_packet_data = 1; tick(); idle();
        checks++; if (tx_packet_data !== 8'h11) begin errors++; $display("FAIL coll_data got %h want 11", tx_packet_data); end
        checks++; if (underflow_err !== 1'b1 || rx_data !== 8'h41 || pkt_occupancy !== 7'd0) begin
            errors++; $display("FAIL coll_pop got %b/%h/%0d want 1/41/0", underflow_err, rx_data, pkt_occupancy); end
        tick();
    endtask

    task automatic test_independent();
        host_ep = 0; store_tx_data = 1; tx_data = 8'h55;
        pkt_ep = 2; store_rx_packet_data = 1; rx_packet_data = 8'h66;
        tick(); idle();
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL indep_ovf got %b want 0", overflow_err); end
        host_ep = 2; pkt_ep = 0;
        checks++; if (buffer_occupancy !== 7'd1 || pkt_occupancy !== 7'd1) begin errors++; $display("FAIL indep_occ got %0d/%0d want 1/1", buffer_occupancy, pkt_occupancy); end
        get_rx_data = 1; get_tx_packet_data = 1; tick(); idle();
        checks++; if (rx_data !== 8'h66 || tx_packet_data !== 8'h55) begin errors++; $display("FAIL indep_data got %h/%h want 66/55", rx_data, tx_packet_data); end
        checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL indep_unf got %b want 0", underflow_err); end
    endtask

    task automatic test_mid_reset();
        host_ep = 1; store_tx_data = 1; tx_data = 8'h77; tick(); idle();
        checks++; if (buffer_occupancy !== 7'd1) begin errors++; $display("FAIL mrst_pre got %0d want 1", buffer_occupancy); end
        store_tx_data = 1; #2; rst = 1; #1;
        checks++; if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
            errors++; $display("FAIL mrst_async got %0d/%h/%h want 0/00/00", buffer_occupancy, rx_data, tx_packet_data); end
        idle(); tick(); rst = 0; tick();
        checks++; if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL mrst_post got %0d want 0", buffer_occupancy); end
    endtask

`ifdef USB_EP_BUF_WATERMARK_EN
    task automatic test_watermark();
        host_ep = 0; store_tx_data = 1;
        for (int i = 0; i < 47; i++) begin
            tx_data = 8'(i);
            tick();
        end
        checks++; if (host_almost_full !== 1'b0) begin errors++; $display("FAIL wm_47 got %b want 0", host_almost_full); end
        tick();
        checks++; if (host_almost_full !== 1'b1) begin errors++; $display("FAIL wm_48 got %b want 1", host_almost_full); end
        for (int i = 0; i < 16; i++) tick();
        checks++; if (ovf_sticky[0] !== 1'b0) begin errors++; $display("FAIL wm_nosticky got %b want 0", ovf_sticky[0]); end
        tick(); idle();
        checks++; if (ovf_sticky !== 4'b0001) begin errors++; $display("FAIL wm_sticky got %b want 0001", ovf_sticky); end
        tick();
        checks++; if (ovf_sticky[0] !== 1'b1 || overflow_err !== 1'b0) begin errors++; $display("FAIL wm_hold got %b/%b want 1/0", ovf_sticky[0], overflow_err); end
        clear = 1; tick(); idle();
        checks++; if (ovf_sticky[0] !== 1'b0 || buffer_occupancy !== 7'd0) begin errors++; $display("FAIL wm_clear got %b/%0d want 0/0", ovf_sticky[0], buffer_occupancy); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_flush_priority();
        test_collision();
        test_independent();
        test_mid_reset();
`ifdef USB_EP_BUF_WATERMARK_EN
        test_watermark();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
